// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned FSTATE_W   = 2;
   localparam int unsigned MSTATE_W   = 2;

   typedef logic [REG_ADDR_W-1:0] creg_addr_t;
   typedef logic [FSTATE_W-1:0]   fetch_state_t;
   typedef logic [MSTATE_W-1:0]   mem_state_t;

   localparam logic [FSTATE_W-1:0] F_REQ  = 2'd0;
   localparam logic [FSTATE_W-1:0] F_HOLD = 2'd1;
   localparam logic [FSTATE_W-1:0] F_DROP = 2'd2;

   localparam logic [MSTATE_W-1:0] M_IDLE = 2'd0;
   localparam logic [MSTATE_W-1:0] M_WAIT = 2'd1;
   localparam logic [MSTATE_W-1:0] M_HOLD = 2'd2;

   typedef struct packed {
      logic stall;
      logic flush;
   } stage_ctl_t;

   // True when a source operand is actually read and names the given register.
   function automatic logic src_match(creg_addr_t src, creg_addr_t dst, logic use_src);
      return use_src & (src == dst);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake and hazard signals between the pipeline datapath and its controller.
interface pipeline_ctrl_if;
   import pipeline_ctrl_pkg::*;

   logic       i_data_ok;
   logic       i_req;
   logic       f_valid;
   logic       d_memop;
   logic       d_data_ok;
   logic       d_req;
   logic       memreadE;
   creg_addr_t rdE;
   creg_addr_t rs1D;
   creg_addr_t rs2D;
   logic       use_rs1D;
   logic       use_rs2D;
   logic       redirectE;
   logic       pc_sel;
   logic       stallF;
   logic       stallD;
   logic       stallE;
   logic       stallM;
   logic       flushD;
   logic       flushE;
   logic       flushW;

   modport master (
      input  i_data_ok, d_memop, d_data_ok, memreadE, rdE, rs1D, rs2D,
             use_rs1D, use_rs2D, redirectE,
      output i_req, f_valid, d_req, pc_sel, stallF, stallD, stallE, stallM,
             flushD, flushE, flushW
   );

   modport slave (
      output i_data_ok, d_memop, d_data_ok, memreadE, rdE, rs1D, rs2D,
             use_rs1D, use_rs2D, redirectE,
      input  i_req, f_valid, d_req, pc_sel, stallF, stallD, stallE, stallM,
             flushD, flushE, flushW
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use interlock detection between the E-stage load and D-stage sources.
module pipeline_ctrl_hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic       memread_e,
   input  creg_addr_t rd_e,
   input  creg_addr_t rs1_d,
   input  creg_addr_t rs2_d,
   input  logic       use_rs1_d,
   input  logic       use_rs2_d,
   output logic       lu_c
);

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign lu_c = memread_e & (rd_e != '0)
               & (src_match(rs1_d, rd_e, use_rs1_d) | src_match(rs2_d, rd_e, use_rs2_d));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: owns ibus/dbus
// handshakes and produces per-stage stall/flush plus redirect select.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   pipeline_ctrl_if.master bus
);

   fetch_state_t fstate;
   fetch_state_t fstate_nxt;
   mem_state_t   mstate;
   mem_state_t   mstate_nxt;

   logic       lu_c;
   logic       d_req_c;
   logic       fetch_busy_c;
   logic       mem_busy_c;
   logic       frz_c;
   logic       redir_c;
   logic       i_req_c;
   logic       f_valid_c;
   logic       pc_sel_c;
   logic       stall_f_c;
   logic       stall_m_c;
   logic       flush_w_c;
   stage_ctl_t ctl_d_c;
   stage_ctl_t ctl_e_c;

   pipeline_ctrl_hazard_detect u_hazard (
      .memread_e (bus.memreadE),
      .rd_e      (bus.rdE),
      .rs1_d     (bus.rs1D),
      .rs2_d     (bus.rs2D),
      .use_rs1_d (bus.use_rs1D),
      .use_rs2_d (bus.use_rs2D),
      .lu_c      (lu_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fstate <= F_REQ;
         mstate <= M_IDLE;
      end else begin
         fstate <= fstate_nxt;
         mstate <= mstate_nxt;
      end
   end

   // A completed dbus access parked in M_HOLD must not be requested again.
   assign d_req_c      = (mstate == M_WAIT) | ((mstate == M_IDLE) & bus.d_memop);
   assign fetch_busy_c = ((fstate == F_REQ) & ~bus.i_data_ok) | (fstate == F_DROP);
   assign mem_busy_c   = d_req_c & ~bus.d_data_ok;
   assign frz_c        = fetch_busy_c | mem_busy_c;
   assign redir_c      = bus.redirectE & ~mem_busy_c;

   always_comb begin
      fstate_nxt = fstate;
      mstate_nxt = mstate;
      i_req_c    = 1'b0;
      f_valid_c  = 1'b0;
      pc_sel_c   = 1'b0;
      stall_f_c  = 1'b0;
      stall_m_c  = 1'b0;
      flush_w_c  = 1'b0;
      ctl_d_c    = '0;
      ctl_e_c    = '0;

      case (fstate)
         F_REQ: begin
            i_req_c = 1'b1;
            if (bus.i_data_ok) begin
               if (frz_c) fstate_nxt = F_HOLD;
               else       f_valid_c  = 1'b1;
            end else if (redir_c) begin
               fstate_nxt = F_DROP;
            end
         end
         F_HOLD: begin
            if (redir_c) begin
               fstate_nxt = F_REQ;
            end else if (!frz_c) begin
               f_valid_c  = 1'b1;
               fstate_nxt = F_REQ;
            end
         end
         F_DROP: begin
            i_req_c = 1'b1;
            if (bus.i_data_ok) fstate_nxt = F_REQ;
         end
         default: fstate_nxt = F_REQ;
      endcase

      case (mstate)
         M_IDLE: begin
            if (bus.d_memop) begin
               if (!bus.d_data_ok)   mstate_nxt = M_WAIT;
               else if (fetch_busy_c) mstate_nxt = M_HOLD;
            end
         end
         M_WAIT: begin
            if (bus.d_data_ok) mstate_nxt = fetch_busy_c ? M_HOLD : M_IDLE;
         end
         M_HOLD: begin
            if (!fetch_busy_c) mstate_nxt = M_IDLE;
         end
         default: mstate_nxt = M_IDLE;
      endcase

      // Hazard priority: dbus wait, redirect, ibus wait, load-use.
      if (mem_busy_c || (!redir_c && fetch_busy_c)) begin
         stall_f_c     = 1'b1;
         ctl_d_c.stall = 1'b1;
         ctl_e_c.stall = 1'b1;
         stall_m_c     = 1'b1;
         flush_w_c     = 1'b1;
      end else if (redir_c) begin
         pc_sel_c      = 1'b1;
         ctl_d_c.flush = 1'b1;
         ctl_e_c.flush = 1'b1;
      end else if (lu_c) begin
         stall_f_c     = 1'b1;
         ctl_d_c.stall = 1'b1;
         ctl_e_c.flush = 1'b1;
      end
   end

   assign bus.i_req   = i_req_c       & ~reset;
   assign bus.f_valid = f_valid_c     & ~reset;
   assign bus.d_req   = d_req_c       & ~reset;
   assign bus.pc_sel  = pc_sel_c      & ~reset;
   assign bus.stallF  = stall_f_c     & ~reset;
   assign bus.stallD  = ctl_d_c.stall & ~reset;
   assign bus.stallE  = ctl_e_c.stall & ~reset;
   assign bus.stallM  = stall_m_c     & ~reset;
   assign bus.flushD  = ctl_d_c.flush & ~reset;
   assign bus.flushE  = ctl_e_c.flush & ~reset;
   assign bus.flushW  = flush_w_c     & ~reset;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   bit   done;

   pipeline_ctrl_if bus_if ();

   pipeline_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: a fetched instruction parked upstream, an in-flight fetch
   // that must be thrown away, a dbus access awaiting its ok, a completed
   // dbus access waiting for the freeze to end.
   bit m_held, m_stale, m_wait, m_done;

   task automatic chk(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_if.i_data_ok = 1'b0;
      bus_if.d_memop   = 1'b0;
      bus_if.d_data_ok = 1'b0;
      bus_if.memreadE  = 1'b0;
      bus_if.rdE       = '0;
      bus_if.rs1D      = '0;
      bus_if.rs2D      = '0;
      bus_if.use_rs1D  = 1'b0;
      bus_if.use_rs2D  = 1'b0;
      bus_if.redirectE = 1'b0;
   endtask

   task automatic do_reset();
      next_cycle();
      reset = 1'b1;
      idle_inputs();
      #1;
      chk("rst_f_valid", bus_if.f_valid, 1'b0);
      chk("rst_d_req",   bus_if.d_req,   1'b0);
      chk("rst_pc_sel",  bus_if.pc_sel,  1'b0);
      chk("rst_stallF",  bus_if.stallF,  1'b0);
      chk("rst_flushW",  bus_if.flushW,  1'b0);
      next_cycle();
      reset = 1'b0;
   endtask

   // Per-cycle reference: outputs from the current inputs and model state,
   // then advance the model with the values the DUT samples at the next edge.
   initial begin
      logic fb, dreq, mb, frz, rd, luv, fv, ireq;
      logic sf, sd, se, sm, fd, fe, fw, pc;
      logic [10:0] exp_v, act_v;
      bit n_held, n_stale, n_wait, n_done;
      forever begin
         @(negedge clk);
         if (done) break;
         act_v = {bus_if.i_req, bus_if.f_valid, bus_if.d_req, bus_if.pc_sel,
                  bus_if.stallF, bus_if.stallD, bus_if.stallE, bus_if.stallM,
                  bus_if.flushD, bus_if.flushE, bus_if.flushW};
         if (reset) begin
            exp_v = '0;
            n_held = 0; n_stale = 0; n_wait = 0; n_done = 0;
         end else begin
            ireq = !m_held;
            fb   = m_stale || (!m_held && !bus_if.i_data_ok);
            dreq = !m_done && (m_wait || bus_if.d_memop);
            mb   = dreq && !bus_if.d_data_ok;
            frz  = fb || mb;
            rd   = bus_if.redirectE && !mb;
            luv  = bus_if.memreadE && (bus_if.rdE != 0) &&
                   ((bus_if.use_rs1D && bus_if.rs1D == bus_if.rdE) ||
                    (bus_if.use_rs2D && bus_if.rs2D == bus_if.rdE));
            fv   = !m_stale && !frz && (m_held ? !rd : bus_if.i_data_ok);
            {sf, sd, se, sm, fd, fe, fw, pc} = '0;
            if (mb)            {sf, sd, se, sm, fw} = 5'b11111;
            else if (rd)       {pc, fd, fe} = 3'b111;
            else if (fb)       {sf, sd, se, sm, fw} = 5'b11111;
            else if (luv)      {sf, sd, fe} = 3'b111;
            exp_v = {ireq, fv, dreq, pc, sf, sd, se, sm, fd, fe, fw};

            n_held = 0; n_stale = 0;
            if (m_stale)     n_stale = !bus_if.i_data_ok;
            else if (m_held) n_held  = frz && !rd;
            else begin
               n_held  = bus_if.i_data_ok && frz;
               n_stale = !bus_if.i_data_ok && rd;
            end
            n_wait = 0; n_done = 0;
            if (m_done)    n_done = fb;
            else if (dreq) begin
               n_wait = !bus_if.d_data_ok;
               n_done = bus_if.d_data_ok && fb;
            end
         end
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle_outputs: got %b expected %b (ireq fval dreq pcsel sF sD sE sM fD fE fW) at %0t",
                     act_v, exp_v, $time);
         end
         m_held = n_held; m_stale = n_stale; m_wait = n_wait; m_done = n_done;
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      done        = 0;
      reset       = 1'b1;
      idle_inputs();

      // Straight-line fetch, no hazards.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus_if.i_data_ok = 1'b1;
         #1;
         chk("run_i_req",   bus_if.i_req,   1'b1);
         chk("run_f_valid", bus_if.f_valid, 1'b1);
         chk("run_stallF",  bus_if.stallF,  1'b0);
         chk("run_flushE",  bus_if.flushE,  1'b0);
         next_cycle();
      end

      // Load-use interlock, and the r0 / unused-source exemptions.
      do_reset();
      bus_if.i_data_ok = 1'b1;
      bus_if.memreadE = 1'b1; bus_if.rdE = 5'd5; bus_if.rs1D = 5'd5; bus_if.use_rs1D = 1'b1;
      #1;
      chk("lu_stallF", bus_if.stallF, 1'b1);
      chk("lu_stallD", bus_if.stallD, 1'b1);
      chk("lu_flushE", bus_if.flushE, 1'b1);
      chk("lu_stallE", bus_if.stallE, 1'b0);
      next_cycle();
      bus_if.memreadE = 1'b0;
      #1;
      chk("lu_release", bus_if.stallD, 1'b0);
      next_cycle();
      bus_if.memreadE = 1'b1; bus_if.rdE = 5'd0; bus_if.rs1D = 5'd0;
      #1;
      chk("lu_r0", bus_if.stallD, 1'b0);
      next_cycle();
      bus_if.rdE = 5'd7; bus_if.rs2D = 5'd7; bus_if.use_rs1D = 1'b0; bus_if.use_rs2D = 1'b1;
      #1;
      chk("lu_rs2", bus_if.stallD, 1'b1);
      next_cycle();
      bus_if.use_rs2D = 1'b0;
      #1;
      chk("lu_unused_src", bus_if.stallD, 1'b0);
      next_cycle();

      // Three-cycle dbus access with the ibus always ready.
      do_reset();
      bus_if.i_data_ok = 1'b1; bus_if.d_memop = 1'b1;
      #1;
      chk("mem1_d_req",   bus_if.d_req,   1'b1);
      chk("mem1_stallM",  bus_if.stallM,  1'b1);
      chk("mem1_flushW",  bus_if.flushW,  1'b1);
      chk("mem1_f_valid", bus_if.f_valid, 1'b0);
      next_cycle();
      #1;
      chk("mem2_d_req", bus_if.d_req, 1'b1);
      chk("mem2_i_req", bus_if.i_req, 1'b0);
      chk("mem2_stallF", bus_if.stallF, 1'b1);
      next_cycle();
      bus_if.d_data_ok = 1'b1;
      #1;
      chk("mem3_d_req",   bus_if.d_req,   1'b1);
      chk("mem3_stallM",  bus_if.stallM,  1'b0);
      chk("mem3_flushW",  bus_if.flushW,  1'b0);
      chk("mem3_f_valid", bus_if.f_valid, 1'b1);
      next_cycle();
      bus_if.d_memop = 1'b0; bus_if.d_data_ok = 1'b0;
      #1;
      chk("mem4_d_req",   bus_if.d_req,   1'b0);
      chk("mem4_f_valid", bus_if.f_valid, 1'b1);
      next_cycle();

      // Redirect while a fetch is outstanding: the stale response is dropped.
      do_reset();
      bus_if.redirectE = 1'b1;
      #1;
      chk("rdr1_pc_sel", bus_if.pc_sel, 1'b1);
      chk("rdr1_flushD", bus_if.flushD, 1'b1);
      chk("rdr1_flushE", bus_if.flushE, 1'b1);
      chk("rdr1_stallF", bus_if.stallF, 1'b0);
      next_cycle();
      bus_if.redirectE = 1'b0;
      #1;
      chk("rdr2_i_req",  bus_if.i_req,   1'b1);
      chk("rdr2_stallF", bus_if.stallF,  1'b1);
      next_cycle();
      bus_if.i_data_ok = 1'b1;
      #1;
      chk("rdr3_f_valid", bus_if.f_valid, 1'b0);
      chk("rdr3_stallD",  bus_if.stallD,  1'b1);
      next_cycle();
      #1;
      chk("rdr4_f_valid", bus_if.f_valid, 1'b1);
      chk("rdr4_stallF",  bus_if.stallF,  1'b0);
      next_cycle();

      // dbus completes while ibus is busy: held without reissue.
      do_reset();
      bus_if.d_memop = 1'b1; bus_if.d_data_ok = 1'b1;
      #1;
      chk("mh1_d_req",  bus_if.d_req,  1'b1);
      chk("mh1_stallM", bus_if.stallM, 1'b1);
      next_cycle();
      bus_if.d_data_ok = 1'b0;
      #1;
      chk("mh2_d_req",  bus_if.d_req,  1'b0);
      chk("mh2_stallM", bus_if.stallM, 1'b1);
      next_cycle();
      bus_if.i_data_ok = 1'b1;
      #1;
      chk("mh3_d_req",   bus_if.d_req,   1'b0);
      chk("mh3_stallM",  bus_if.stallM,  1'b0);
      chk("mh3_f_valid", bus_if.f_valid, 1'b1);
      next_cycle();
      bus_if.d_memop = 1'b0;
      #1;
      chk("mh4_d_req", bus_if.d_req, 1'b0);
      next_cycle();

      // Redirect held back by a dbus wait acts on the release cycle.
      do_reset();
      bus_if.i_data_ok = 1'b1; bus_if.d_memop = 1'b1; bus_if.redirectE = 1'b1;
      #1;
      chk("rw1_pc_sel", bus_if.pc_sel, 1'b0);
      chk("rw1_stallE", bus_if.stallE, 1'b1);
      next_cycle();
      bus_if.i_data_ok = 1'b0;
      #1;
      chk("rw2_pc_sel", bus_if.pc_sel, 1'b0);
      next_cycle();
      bus_if.d_data_ok = 1'b1;
      #1;
      chk("rw3_pc_sel",  bus_if.pc_sel,  1'b1);
      chk("rw3_flushD",  bus_if.flushD,  1'b1);
      chk("rw3_flushE",  bus_if.flushE,  1'b1);
      chk("rw3_stallE",  bus_if.stallE,  1'b0);
      chk("rw3_f_valid", bus_if.f_valid, 1'b0);
      next_cycle();
      idle_inputs();
      bus_if.i_data_ok = 1'b1;
      #1;
      chk("rw4_pc_sel",  bus_if.pc_sel,  1'b0);
      chk("rw4_f_valid", bus_if.f_valid, 1'b1);
      next_cycle();

      // Randomized traffic, checked by the per-cycle model.
      for (int i = 0; i < 3000; i++) begin
         reset            = ($urandom_range(0, 99) == 0);
         bus_if.i_data_ok = ($urandom_range(0, 9) < 6);
         bus_if.d_memop   = ($urandom_range(0, 9) < 3);
         bus_if.d_data_ok = ($urandom_range(0, 9) < 5);
         bus_if.memreadE  = 1'($urandom_range(0, 1));
         bus_if.rdE       = 5'($urandom_range(0, 3));
         bus_if.rs1D      = 5'($urandom_range(0, 3));
         bus_if.rs2D      = 5'($urandom_range(0, 3));
         bus_if.use_rs1D  = 1'($urandom_range(0, 1));
         bus_if.use_rs2D  = 1'($urandom_range(0, 1));
         bus_if.redirectE = ($urandom_range(0, 9) < 2);
         next_cycle();
      end

      @(posedge clk);
      done = 1;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
